qspi_flash_responder: RTL
=========================

# qspi_flash_responder

Single-clock QSPI target that models the serial-flash side of the bus driven by the team's QSPI master, for simulation benches and FPGA loop-back. It oversamples `sclk_i`, `cs_ni` and `io` on `clk_i` and decodes the command subset the master issues: WREN, WRDI, RDSR1, RDID, READ, PP, QOR and QPP. The target contains a byte-wide internal array that a side-band bus port can preload and inspect.

## Interface
- `DEPTH`, default 256: bytes of internal array, power of two. The flash address is taken modulo `DEPTH`.
- `AW`, default 8: log2(`DEPTH`).
- `ID`, default 24'h01_02_19: RDID response, sent MSB first.
- `clk_i` in 1: the only clock. All logic is on `posedge clk_i`.
- `rst_i` in 1: reset, asynchronous, active-high.
- `sclk_i` in 1: serial clock from the master. Idles high (mode 3).
- `cs_ni` in 1: chip select, active low.
- `io` inout 4: serial data. `io[0]` is MOSI in x1, `io[1]` is MISO in x1, and all four lanes carry data in quad.
- `mem_we_i` in 1: side-band byte write strobe.
- `mem_addr_i` in AW: side-band byte address.
- `mem_wdata_i` in 8: side-band write data.
- `mem_rdata_o` out 8: side-band read data, registered one cycle after the address.
- `busy_o` out 1: high while `cs_ni` (synchronized) is low.
- `wel_o` out 1: write-enable latch.

## Operation
- **Input synchronization.** `sclk_i`, `cs_ni` and `io[3:0]` each pass through a 2-flop synchronizer. A third flop gives edge detection.
  - rise_sclk = synced sclk 0→1.
  - fall_sclk = synced sclk 1→0.
  - cs_fall and cs_rise are detected the same way on synced `cs_ni`.
- **Sampling and shifting.** Incoming bits are sampled on rise_sclk. Outgoing bits are updated on fall_sclk. Every field is MSB first, including the bit order within each byte.
- **State machine.** States are IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, STAT, IGNORE.
- **IDLE.** On cs_fall: go to CMD, clear the bit counter, release all `io` lanes.
- **CMD.** Shift 8 bits from `io[0]`. On the 8th rise_sclk, decode the opcode:
  - 06 (WREN): set WEL, go to IGNORE.
  - 04 (WRDI): clear WEL, go to IGNORE.
  - 05 (RDSR1): go to STAT. The status byte is {6'b0, WEL, 1'b0}; WIP is always 0.
  - 9F (RDID): go to RDATA with the `ID` shift source, 3 bytes, then 0xFF.
  - 03 (READ), 02 (PP), 6B (QOR), 32 (QPP): go to ADDR.
  - Any other opcode: go to IGNORE.
- **ADDR.** Shift 24 bits from `io[0]`. The low AW bits load the byte pointer.
  - 03: go to RDATA, x1.
  - 6B: go to DUMMY.
  - 02 and 32: go to WDATA, x1 and x4 respectively.
- **DUMMY.** Count 8 rise_sclk, then go to RDATA, x4.
- **RDATA and STAT (target drives data).**
  - x1 drives `io[1]` only. x4 drives all of `io[3:0]`, high nibble first.
  - The first bit or nibble is presented on the fall_sclk that follows the last ADDR, DUMMY or CMD rise_sclk.
  - After each byte, the pointer increments modulo `DEPTH`. Reads continue indefinitely; there is no wrap boundary other than `DEPTH`.
  - STAT repeats the status byte until cs rises.
- **WDATA (program).**
  - x1 samples `io[0]`. x4 samples `io[3:0]`, high nibble first.
  - Each completed byte is written to the array only if WEL=1. The write is a plain overwrite, not the flash AND semantics. The pointer then increments modulo `DEPTH`.
  - A partial byte at cs_rise is discarded.
- **End of transaction.** cs_rise from any state:
  - Go to IDLE and release every `io` lane.
  - If the transaction was 02 or 32 and WEL was set, clear WEL.
- **Side-band port.**
  - `mem_we_i` has priority over a QSPI byte write to the same cycle. The QSPI write is then dropped. This collision is the bench's responsibility to avoid.
  - The side-band read is independent of QSPI activity.
- **Reset mid-transaction.** `rst_i` forces IDLE, tri-states `io`, and clears WEL, the counters and the synchronizers (sclk syncs reset to 1, cs syncs reset to 1). Array contents are not reset.

## Timing
- Reset values:
  - `io` = 4'bzzzz.
  - `busy_o` = 0.
  - `wel_o` = 0.
  - `mem_rdata_o` = 0.
  - State = IDLE.
- Pin-to-event latency is 3 `clk_i` cycles (2 sync flops + edge flop). Output drive registers update 1 cycle after the event, so output is 4 `clk_i` cycles after the pin edge.
- Requirement: each sclk half-period must be at least 6 `clk_i` cycles. With this block on the same `clk_i` as the master, this means master prescaler ≥ 5.
- `io` is released within 4 `clk_i` cycles after `cs_ni` rises.
- `busy_o` follows synced `cs_ni` with 2 cycles of latency.
- `wel_o` changes on the 8th CMD rise_sclk for WREN/WRDI, and on cs_rise for the clear after a program.
- A side-band write is visible to a QSPI read whose byte load occurs at least 1 cycle later.

## Test plan
- **RDSR1 after reset:** cs low, shift 05, clock 8 more sclk → `io[1]` reads 0x00. Then WREN, then RDSR1 → reads 0x02 and `wel_o`=1.
- **x1 read with wrap:** preload addr 0xFE=0xA5 and 0xFF=0x3C, 0x00=0x81. Send 03 + 0x0000FE, read 3 bytes → A5, 3C, 81.
- **QOR:** preload 0x10..0x13 = 11,22,33,44. Send 6B + 0x000010 + 8 dummy clocks, read 8 nibbles on `io[3:0]` → 1,1,2,2,3,3,4,4. `io` is driven only after the dummy phase.
- **PP gated by WEL:** PP 0x20 data 0x5A without WREN → side-band read at 0x20 is unchanged. WREN, then QPP 0x20 nibbles 5,A,C,3 → bytes 5A, C3, and `wel_o`=0 after cs rises.
- **Abort:** cs rises after 5 bits of a PP data byte → no write. Next command decodes normally.
- **Async reset:** assert `rst_i` mid-QOR data phase → `io` is Z within 1 cycle and state is IDLE. A following RDID returns 01 02 19.

Source files
------------

// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder
// Serial-flash target for the QSPI master. It oversamples sclk/cs/io on clk_i
// and decodes WREN, WRDI, RDSR1, RDID, READ, PP, QOR and QPP against a
// byte-wide internal array. A side-band port can preload and inspect the array.
module qspi_flash_responder #(
  parameter int          DEPTH = 256,
  parameter int          AW    = 8,
  parameter logic [23:0] ID    = 24'h01_02_19
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          sclk_i,
  input  logic          cs_ni,
  inout  wire  [3:0]    io,
  input  logic          mem_we_i,
  input  logic [AW-1:0] mem_addr_i,
  input  logic [7:0]    mem_wdata_i,
  output logic [7:0]    mem_rdata_o,
  output logic          busy_o,
  output logic          wel_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_RDATA  = 3'd4,
    ST_WDATA  = 3'd5,
    ST_STAT   = 3'd6,
    ST_IGNORE = 3'd7
  } state_e;

  // Where the next outgoing byte comes from while the target drives the bus.
  typedef enum logic [1:0] {
    SRC_MEM  = 2'd0,
    SRC_ID   = 2'd1,
    SRC_STAT = 2'd2
  } src_e;

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR1 = 8'h05;
  localparam logic [7:0] OP_RDID  = 8'h9F;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_PP    = 8'h02;
  localparam logic [7:0] OP_QOR   = 8'h6B;
  localparam logic [7:0] OP_QPP   = 8'h32;

  // Status register 1: WIP is never set, WEL sits in bit 1.
  function automatic logic [7:0] status_byte(input logic wel);
    return {6'b000000, wel, 1'b0};
  endfunction

  // JEDEC ID bytes MSB first, then 0xFF for ever.
  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = ID[23:16];
      2'd1:    b = ID[15:8];
      2'd2:    b = ID[7:0];
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  // Backing array (not reset: contents survive rst_i).
  logic [7:0] mem_q [DEPTH];

  // Synchronizers and edge flops.
  logic [1:0] sclk_sync_q;
  logic       sclk_dly_q;
  logic [1:0] cs_sync_q;
  logic       cs_dly_q;
  logic [3:0] io_s1_q;
  logic [3:0] io_s2_q;

  logic       rise_sclk_s;
  logic       fall_sclk_s;
  logic       cs_fall_s;
  logic       cs_rise_s;
  logic       din_s;
  logic [7:0] cmd_s;
  logic [23:0] addr_s;
  logic       last_s;
  logic [AW-1:0] ptr_inc_s;
  logic [1:0] id_nxt_s;

  // Protocol state.
  state_e        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [23:0]   sr_q, sr_d;
  logic [7:0]    op_q, op_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [1:0]    id_idx_q, id_idx_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic          quad_q, quad_d;
  src_e          src_q, src_d;
  logic          wel_q, wel_d;
  logic [3:0]    oe_q, oe_d;
  logic [3:0]    out_q, out_d;
  logic          busy_q;
  logic [7:0]    mem_rdata_q;

  logic          qspi_we_s;
  logic [7:0]    qspi_wdata_s;

  assign rise_sclk_s = sclk_sync_q[1] & ~sclk_dly_q;
  assign fall_sclk_s = ~sclk_sync_q[1] & sclk_dly_q;
  assign cs_fall_s   = ~cs_sync_q[1] & cs_dly_q;
  assign cs_rise_s   = cs_sync_q[1] & ~cs_dly_q;
  assign din_s       = io_s2_q[0];
  assign cmd_s       = {sr_q[6:0], din_s};
  assign addr_s      = {sr_q[22:0], din_s};
  assign ptr_inc_s   = ptr_q + AW'(1);
  assign id_nxt_s    = (id_idx_q == 2'd3) ? 2'd3 : (id_idx_q + 2'd1);
  // Byte boundary: 8 bits in x1, 2 nibbles in x4.
  assign last_s      = quad_q ? cnt_q[0] : (cnt_q[2:0] == 3'd7);

  // Tri-state drivers for the four io lanes.
  for (genvar g = 0; g < 4; g++) begin : g_io
    assign io[g] = oe_q[g] ? out_q[g] : 1'bz;
  end

  assign wel_o       = wel_q;
  assign busy_o      = busy_q;
  assign mem_rdata_o = mem_rdata_q;

  // Two-flop synchronizers plus one edge-detect flop per input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_sync_q <= 2'b11;
      sclk_dly_q  <= 1'b1;
      cs_sync_q   <= 2'b11;
      cs_dly_q    <= 1'b1;
      io_s1_q     <= 4'h0;
      io_s2_q     <= 4'h0;
      busy_q      <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk_i};
      sclk_dly_q  <= sclk_sync_q[1];
      cs_sync_q   <= {cs_sync_q[0], cs_ni};
      cs_dly_q    <= cs_sync_q[1];
      io_s1_q     <= io;
      io_s2_q     <= io_s1_q;
      busy_q      <= ~cs_sync_q[1];
    end
  end

  // Protocol state register and output drive registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      sr_q     <= 24'h000000;
      op_q     <= 8'h00;
      ptr_q    <= '0;
      id_idx_q <= 2'd0;
      tx_q     <= 8'h00;
      rx_q     <= 8'h00;
      quad_q   <= 1'b0;
      src_q    <= SRC_MEM;
      wel_q    <= 1'b0;
      oe_q     <= 4'b0000;
      out_q    <= 4'b0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      op_q     <= op_d;
      ptr_q    <= ptr_d;
      id_idx_q <= id_idx_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      quad_q   <= quad_d;
      src_q    <= src_d;
      wel_q    <= wel_d;
      oe_q     <= oe_d;
      out_q    <= out_d;
    end
  end

  // Next-state decode: command/address shifting, data shifting in both directions.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    op_d         = op_q;
    ptr_d        = ptr_q;
    id_idx_d     = id_idx_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    quad_d       = quad_q;
    src_d        = src_q;
    wel_d        = wel_q;
    oe_d         = oe_q;
    out_d        = out_q;
    qspi_we_s    = 1'b0;
    qspi_wdata_s = 8'h00;

    if (cs_rise_s) begin
      // End of transaction from any state; a program clears the latch.
      state_d = ST_IDLE;
      cnt_d   = 5'd0;
      oe_d    = 4'b0000;
      out_d   = 4'b0000;
      if (((op_q == OP_PP) || (op_q == OP_QPP)) && wel_q) begin
        wel_d = 1'b0;
      end else begin
        wel_d = wel_q;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall_s) begin
            state_d = ST_CMD;
            cnt_d   = 5'd0;
            op_d    = 8'h00;
            oe_d    = 4'b0000;
            out_d   = 4'b0000;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_CMD: begin
          if (rise_sclk_s) begin
            sr_d = addr_s;
            if (cnt_q == 5'd7) begin
              cnt_d = 5'd0;
              op_d  = cmd_s;
              case (cmd_s)
                OP_WREN: begin
                  wel_d   = 1'b1;
                  state_d = ST_IGNORE;
                end
                OP_WRDI: begin
                  wel_d   = 1'b0;
                  state_d = ST_IGNORE;
                end
                OP_RDSR1: begin
                  state_d = ST_STAT;
                  src_d   = SRC_STAT;
                  quad_d  = 1'b0;
                  tx_d    = status_byte(wel_q);
                end
                OP_RDID: begin
                  state_d  = ST_RDATA;
                  src_d    = SRC_ID;
                  quad_d   = 1'b0;
                  id_idx_d = 2'd0;
                  tx_d     = id_byte(2'd0);
                end
                OP_READ, OP_PP, OP_QOR, OP_QPP: begin
                  state_d = ST_ADDR;
                end
                default: begin
                  state_d = ST_IGNORE;
                end
              endcase
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end else begin
            state_d = ST_CMD;
          end
        end

        ST_ADDR: begin
          if (rise_sclk_s) begin
            sr_d = addr_s;
            if (cnt_q == 5'd23) begin
              cnt_d = 5'd0;
              ptr_d = addr_s[AW-1:0];
              case (op_q)
                OP_READ: begin
                  state_d = ST_RDATA;
                  src_d   = SRC_MEM;
                  quad_d  = 1'b0;
                  tx_d    = mem_q[addr_s[AW-1:0]];
                end
                OP_QOR: begin
                  state_d = ST_DUMMY;
                end
                OP_PP: begin
                  state_d = ST_WDATA;
                  quad_d  = 1'b0;
                end
                OP_QPP: begin
                  state_d = ST_WDATA;
                  quad_d  = 1'b1;
                end
                default: begin
                  state_d = ST_IGNORE;
                end
              endcase
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end

        ST_DUMMY: begin
          if (rise_sclk_s) begin
            if (cnt_q == 5'd7) begin
              cnt_d   = 5'd0;
              state_d = ST_RDATA;
              src_d   = SRC_MEM;
              quad_d  = 1'b1;
              tx_d    = mem_q[ptr_q];
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end else begin
            state_d = ST_DUMMY;
          end
        end

        ST_RDATA, ST_STAT: begin
          if (fall_sclk_s) begin
            if (quad_q) begin
              oe_d  = 4'b1111;
              out_d = cnt_q[0] ? tx_q[3:0] : tx_q[7:4];
            end else begin
              oe_d  = 4'b0010;
              out_d = {2'b00, tx_q[3'd7 - cnt_q[2:0]], 1'b0};
            end
            if (last_s) begin
              cnt_d = 5'd0;
              case (src_q)
                SRC_MEM: begin
                  ptr_d = ptr_inc_s;
                  tx_d  = mem_q[ptr_inc_s];
                end
                SRC_ID: begin
                  id_idx_d = id_nxt_s;
                  tx_d     = id_byte(id_nxt_s);
                end
                SRC_STAT: begin
                  tx_d = status_byte(wel_q);
                end
                default: begin
                  tx_d = 8'hFF;
                end
              endcase
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end else begin
            state_d = state_q;
          end
        end

        ST_WDATA: begin
          if (rise_sclk_s) begin
            if (quad_q) begin
              rx_d = {rx_q[3:0], io_s2_q};
            end else begin
              rx_d = {rx_q[6:0], din_s};
            end
            if (last_s) begin
              cnt_d        = 5'd0;
              qspi_we_s    = wel_q;
              qspi_wdata_s = rx_d;
              ptr_d        = ptr_inc_s;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end else begin
            state_d = ST_WDATA;
          end
        end

        ST_IGNORE: begin
          state_d = ST_IGNORE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Array write port: the side-band strobe wins over a same-cycle QSPI byte write.
  always_ff @(posedge clk_i) begin
    if (mem_we_i) begin
      mem_q[mem_addr_i] <= mem_wdata_i;
    end else if (qspi_we_s) begin
      mem_q[ptr_q] <= qspi_wdata_s;
    end
  end

  // Side-band registered read, independent of bus activity.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_rdata_q <= 8'h00;
    end else begin
      mem_rdata_q <= mem_q[mem_addr_i];
    end
  end

endmodule
